// File: rtl/dc_fifo_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM master path into the DC FIFO.
// One transaction in flight; request latched at arbitration, response routed to winner.
module dc_fifo_rr_arbiter #(
    parameter int N_PORTS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_PORTS-1:0]           s_req_i,
    input  logic [N_PORTS*32-1:0]        s_add_i,
    input  logic [N_PORTS-1:0]           s_wen_i,
    input  logic [N_PORTS*32-1:0]        s_wdata_i,
    input  logic [N_PORTS*4-1:0]         s_be_i,
    output logic [N_PORTS-1:0]           s_gnt_o,
    output logic [N_PORTS-1:0]           s_r_valid_o,
    output logic [31:0]                  s_r_rdata_o,
    output logic                         m_req_o,
    output logic [31:0]                  m_add_o,
    output logic                         m_wen_o,
    output logic [31:0]                  m_wdata_o,
    output logic [3:0]                   m_be_o,
    input  logic                         m_gnt_i,
    input  logic                         m_r_valid_i,
    input  logic [31:0]                  m_r_rdata_i,
    output logic                         busy_o,
    output logic [$clog2(N_PORTS)-1:0]   owner_o
);

    localparam int IDX_W = $clog2(N_PORTS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RVALID,
        RESPOND
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [31:0]      add_q, add_d;
    logic             wen_q, wen_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      rdata_q, rdata_d;

    // First requesting port at or above rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!win_found && s_req_i[(int'(rr_ptr_q) + i) % N_PORTS]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(rr_ptr_q) + i) % N_PORTS);
            end
        end
    end

    // State and latched request/response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            add_q    <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            add_q    <= add_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next state: arbitrate in IDLE, hold until grant, capture the response.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        add_d    = add_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = ISSUE;
                    owner_d  = win_idx;
                    rr_ptr_d = (win_idx == IDX_W'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;
                    add_d    = s_add_i[32*win_idx +: 32];
                    wen_d    = s_wen_i[win_idx];
                    wdata_d  = s_wdata_i[32*win_idx +: 32];
                    be_d     = s_be_i[4*win_idx +: 4];
                end
            end
            ISSUE: begin
                if (m_gnt_i) state_d = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (m_r_valid_i) begin
                    rdata_d = m_r_rdata_i;
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: downstream request replayed from latches, pulses only to the owner.
    always_comb begin
        m_req_o     = (state_q == ISSUE);
        s_gnt_o     = '0;
        s_r_valid_o = '0;
        if (state_q == ISSUE && m_gnt_i) s_gnt_o[owner_q] = 1'b1;
        if (state_q == RESPOND) s_r_valid_o[owner_q] = 1'b1;
    end

    assign m_add_o     = add_q;
    assign m_wen_o     = wen_q;
    assign m_wdata_o   = wdata_q;
    assign m_be_o      = be_q;
    assign s_r_rdata_o = rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_dc_fifo_rr_arbiter.sv
// Self-checking bench for dc_fifo_rr_arbiter.
// Scoreboard of expected grants/responses plus a 2-port instance.
module tb_dc_fifo_rr_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]    s_req;
    logic [N*32-1:0] s_add;
    logic [N-1:0]    s_wen;
    logic [N*32-1:0] s_wdata;
    logic [N*4-1:0]  s_be;
    logic [N-1:0]    s_gnt;
    logic [N-1:0]    s_rv;
    logic [31:0]     s_rdata;
    logic            m_req;
    logic [31:0]     m_add;
    logic            m_wen;
    logic [31:0]     m_wdata;
    logic [3:0]      m_be;
    logic            m_gnt;
    logic            m_rv;
    logic [31:0]     m_rdata;
    logic            busy;
    logic [1:0]      owner;

    dc_fifo_rr_arbiter #(.N_PORTS(N)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_req_i(s_req), .s_add_i(s_add), .s_wen_i(s_wen),
        .s_wdata_i(s_wdata), .s_be_i(s_be),
        .s_gnt_o(s_gnt), .s_r_valid_o(s_rv), .s_r_rdata_o(s_rdata),
        .m_req_o(m_req), .m_add_o(m_add), .m_wen_o(m_wen),
        .m_wdata_o(m_wdata), .m_be_o(m_be),
        .m_gnt_i(m_gnt), .m_r_valid_i(m_rv), .m_r_rdata_i(m_rdata),
        .busy_o(busy), .owner_o(owner)
    );

    logic [1:0]  b_req;
    logic [63:0] b_add;
    logic [1:0]  b_wen;
    logic [63:0] b_wdata;
    logic [7:0]  b_be;
    logic [1:0]  b_gnt;
    logic [1:0]  b_rv;
    logic [31:0] b_rdata;
    logic        b_m_req;
    logic [31:0] b_m_add;
    logic        b_m_wen;
    logic [31:0] b_m_wdata;
    logic [3:0]  b_m_be;
    logic        b_m_gnt;
    logic        b_m_rv;
    logic [31:0] b_m_rdata;
    logic        b_busy;
    logic        b_owner;

    dc_fifo_rr_arbiter #(.N_PORTS(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .s_req_i(b_req), .s_add_i(b_add), .s_wen_i(b_wen),
        .s_wdata_i(b_wdata), .s_be_i(b_be),
        .s_gnt_o(b_gnt), .s_r_valid_o(b_rv), .s_r_rdata_o(b_rdata),
        .m_req_o(b_m_req), .m_add_o(b_m_add), .m_wen_o(b_m_wen),
        .m_wdata_o(b_m_wdata), .m_be_o(b_m_be),
        .m_gnt_i(b_m_gnt), .m_r_valid_i(b_m_rv), .m_r_rdata_i(b_m_rdata),
        .busy_o(b_busy), .owner_o(b_owner)
    );

    typedef struct {
        int          port;
        logic [31:0] add;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rsp_t;

    exp_t gq[$];
    rsp_t rq[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a == 32'h1A10_0040) ? 32'hCAFE_F00D : (a ^ 32'h5A5A_5A5A);
    endfunction

    // Downstream slave for the 4-port instance.
    int   gnt_delay = 0;
    int   rsp_delay = 0;
    bit   rsp_en = 1'b1;
    int   wcnt = 0;
    int   rvw = 0;
    bit   pend = 1'b0;
    logic [31:0] pdata = '0;

    initial begin
        m_gnt = 1'b0;
        m_rv = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            m_gnt = 1'b0;
            m_rv = 1'b0;
            if (pend) begin
                if (rsp_en && rvw >= rsp_delay) begin
                    m_rv = 1'b1;
                    m_rdata = pdata;
                    pend = 1'b0;
                end else begin
                    rvw++;
                end
            end else if (m_req) begin
                if (wcnt >= gnt_delay) begin
                    m_gnt = 1'b1;
                    pend = 1'b1;
                    rvw = 0;
                    pdata = rd_of(m_add);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Downstream slave for the 2-port instance: immediate grant, next-cycle response.
    bit b_pend = 1'b0;
    initial begin
        b_m_gnt = 1'b0;
        b_m_rv = 1'b0;
        b_m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            b_m_rv = b_pend;
            b_m_rdata = b_m_add ^ 32'h0F0F_0F0F;
            b_pend = 1'b0;
            b_m_gnt = b_m_req;
            if (b_m_req) b_pend = 1'b1;
        end
    end

    int req_run = 0;
    int gnt_run = 0;
    int last_gnt_cyc = 0;
    int last_rv_cyc = 0;
    int rv_cnt = 0;
    exp_t mon_e;
    rsp_t mon_r;

    // Monitor: compare grants, downstream fields and responses to the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_req) begin
                req_run++;
                chk("gnt_vs_mgnt", {63'b0, |s_gnt}, {63'b0, m_gnt});
                if (gq.size() > 0) begin
                    chk("m_add", m_add, gq[0].add);
                    chk("m_wen", m_wen, gq[0].wen);
                    chk("m_wdata", m_wdata, gq[0].wdata);
                    chk("m_be", m_be, gq[0].be);
                end else begin
                    chk("m_req_unexp", m_req, 0);
                end
            end
            if (|s_gnt) begin
                chk("gnt_onehot", $countones(s_gnt), 1);
                if (gq.size() == 0) begin
                    chk("gnt_unexp", s_gnt, 0);
                end else begin
                    mon_e = gq.pop_front();
                    chk("gnt_port", s_gnt, 64'(1) << mon_e.port);
                end
                last_gnt_cyc = cyc;
                gnt_run = req_run;
                req_run = 0;
            end
            if (|s_rv) begin
                rv_cnt++;
                chk("rv_onehot", $countones(s_rv), 1);
                if (rq.size() == 0) begin
                    chk("rv_unexp", s_rv, 0);
                end else begin
                    mon_r = rq.pop_front();
                    chk("rv_port", s_rv, 64'(1) << mon_r.port);
                    chk("rdata", s_rdata, mon_r.data);
                end
                last_rv_cyc = cyc;
            end
        end
    end

    task automatic expect_txn(input int p, input logic [31:0] a, input logic w,
                              input logic [31:0] d, input logic [3:0] b, input bit with_rsp);
        exp_t e;
        rsp_t r;
        e.port = p;
        e.add = a;
        e.wen = w;
        e.wdata = d;
        e.be = b;
        gq.push_back(e);
        if (with_rsp) begin
            r.port = p;
            r.data = rd_of(a);
            rq.push_back(r);
        end
    endtask

    task automatic issue(input int p, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] b);
        bit ok;
        ok = 1'b0;
        s_add[32*p +: 32] = a;
        s_wen[p] = w;
        s_wdata[32*p +: 32] = d;
        s_be[4*p +: 4] = b;
        s_req[p] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_gnt[p]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("gnt_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_req[p] = 1'b0;
    endtask

    task automatic wait_gnt_bit(input int p);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_gnt[p]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_gnt_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && gq.size() == 0 && rq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_req = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic port_seq(input int k);
        for (int t = 0; t < 2; t++)
            issue(k, 32'h1000_0000 + 32'(k * 256 + t * 4), 1'b1, '0, 4'hF);
    endtask

    int t0;
    int n0;
    int prev;
    bit ok6;

    initial begin
        s_req = '0;
        s_add = '0;
        s_wen = '0;
        s_wdata = '0;
        s_be = '0;
        b_req = '0;
        b_add = {32'h5000_0004, 32'h5000_0000};
        b_wen = 2'b11;
        b_wdata = '0;
        b_be = 8'hFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_m_req", m_req, 0);
        chk("rst_s_gnt", s_gnt, 0);
        chk("rst_s_rv", s_rv, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_m_add", m_add, 0);
        chk("rst_m_wen", m_wen, 0);
        chk("rst_b_busy", b_busy, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // single read from port 2
        @(posedge clk);
        #1;
        t0 = cyc;
        expect_txn(2, 32'h1A10_0040, 1'b1, '0, 4'hF, 1'b1);
        issue(2, 32'h1A10_0040, 1'b1, '0, 4'hF);
        wait_idle();
        chk("t1_gnt_lat", last_gnt_cyc - t0, 1);
        chk("t1_rv_lat", last_rv_cyc - t0, 3);
        chk("t1_rdata_hold", s_rdata, 32'hCAFE_F00D);
        chk("t1_owner", owner, 2);

        // all ports requesting continuously
        do_reset();
        for (int t = 0; t < 2; t++)
            for (int k = 0; k < N; k++)
                expect_txn(k, 32'h1000_0000 + 32'(k * 256 + t * 4), 1'b1, '0, 4'hF, 1'b1);
        fork
            port_seq(0);
            port_seq(1);
            port_seq(2);
            port_seq(3);
        join
        wait_idle();
        chk("t2_owner", owner, 3);
        expect_txn(0, 32'h1100_0000, 1'b1, '0, 4'hF, 1'b1);
        expect_txn(3, 32'h1100_0300, 1'b1, '0, 4'hF, 1'b1);
        fork
            issue(3, 32'h1100_0300, 1'b1, '0, 4'hF);
            issue(0, 32'h1100_0000, 1'b1, '0, 4'hF);
        join
        wait_idle();

        // stalled write from port 1, fields disturbed after the latch
        gnt_delay = 4;
        expect_txn(1, 32'h2000_0010, 1'b0, 32'h1234_5678, 4'h3, 1'b1);
        fork
            issue(1, 32'h2000_0010, 1'b0, 32'h1234_5678, 4'h3);
            begin
                repeat (2) @(posedge clk);
                #1;
                s_wdata[63:32] = 32'hDEAD_BEEF;
                s_add[63:32] = 32'h0BAD_0000;
            end
        join
        chk("t3_req_hold", gnt_run, 5);
        gnt_delay = 0;
        wait_idle();

        // port 0 waits out port 3's transaction and wins with its updated address
        rsp_delay = 3;
        expect_txn(3, 32'h4000_0030, 1'b1, '0, 4'hF, 1'b1);
        expect_txn(0, 32'h4000_0B00, 1'b1, '0, 4'hF, 1'b1);
        fork
            issue(3, 32'h4000_0030, 1'b1, '0, 4'hF);
            begin
                wait_gnt_bit(3);
                @(posedge clk);
                #1;
                s_add[31:0] = 32'h4000_0A00;
                s_wen[0] = 1'b1;
                s_wdata[31:0] = '0;
                s_be[3:0] = 4'hF;
                s_req[0] = 1'b1;
                @(posedge clk);
                #1;
                issue(0, 32'h4000_0B00, 1'b1, '0, 4'hF);
                chk("t4_p0_after_rsp", last_gnt_cyc - last_rv_cyc, 2);
            end
        join
        rsp_delay = 0;
        wait_idle();

        // reset while waiting for the response, then a late response
        rsp_en = 1'b0;
        expect_txn(2, 32'h3000_0000, 1'b1, '0, 4'hF, 1'b0);
        issue(2, 32'h3000_0000, 1'b1, '0, 4'hF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_owner", owner, 0);
        chk("t5_rst_m_req", m_req, 0);
        chk("t5_rst_gnt", s_gnt, 0);
        chk("t5_rst_rv", s_rv, 0);
        chk("t5_rst_rdata", s_rdata, 0);
        chk("t5_rst_m_add", m_add, 0);
        chk("t5_rst_m_wdata", m_wdata, 0);
        chk("t5_rst_m_be", m_be, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        n0 = rv_cnt;
        repeat (2) @(posedge clk);
        #1;
        rsp_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t5_no_rv", rv_cnt - n0, 0);
        chk("t5_busy", busy, 0);
        chk("t5_owner", owner, 0);
        chk("t5_rdata", s_rdata, 0);
        chk("t5_late_sent", pend, 0);

        // 2-port instance, only port 1 requesting
        @(posedge clk);
        #1;
        b_req = 2'b10;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            ok6 = 1'b0;
            for (int j = 0; j < 50; j++) begin
                @(negedge clk);
                if (|b_gnt) begin
                    ok6 = 1'b1;
                    break;
                end
            end
            chk("t6_gnt_seen", ok6, 1);
            chk("t6_gnt_port", b_gnt, 2'b10);
            chk("t6_m_add", b_m_add, 32'h5000_0004);
            if (i > 0) chk("t6_spacing", cyc - prev, 4);
            prev = cyc;
        end
        @(posedge clk);
        #1;
        b_req = 2'b00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t6_b_idle", b_busy, 0);
        chk("t6_b_owner", b_owner, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
